// File: rtl/bp_me_wb_pkg.sv
// Shared definitions for the Wishbone slave blocks: FSM state encoding,
// wait-state counter width and a small sizing helper.
package bp_me_wb_pkg;

  // Slave handshake states, reused by every WB slave built on this pattern
  typedef enum logic [1:0] {
    e_wb_idle = 2'd0,
    e_wb_wait = 2'd1,
    e_wb_ack  = 2'd2
  } bp_me_wb_state_e;

  // Wait-state counter width; wide enough for the largest legal wait count
  localparam int unsigned wb_wait_cnt_width_gp = 4;
  localparam int unsigned wb_wait_cycles_max_gp = 15;

  // Index width for an n-entry array, never below one bit
  function automatic int unsigned wb_safe_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous RAM with byte-lane write mask.
//   clk_i        : clock
//   v_i / w_i    : access valid / write (1) or read (0)
//   addr_i       : word index
//   data_i       : write data
//   write_mask_i : per-byte write enables
//   data_o       : read data, valid the cycle after a read access, held otherwise
// Contents are intentionally not reset.
module bsg_mem_1rw_sync_mask_write_byte
  import bp_me_wb_pkg::*;
#(
  parameter  int unsigned els_p         = 256,
  parameter  int unsigned data_width_p  = 64,
  localparam int unsigned addr_width_lp = wb_safe_clog2(els_p),
  localparam int unsigned mask_width_lp = data_width_p / 8
) (
  input  logic                     clk_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [data_width_p-1:0]  data_i,
  input  logic [mask_width_lp-1:0] write_mask_i,
  output logic [data_width_p-1:0]  data_o
);

  logic [data_width_p-1:0] mem_q [els_p];
  logic [data_width_p-1:0] data_q;

  // Storage array and read register; no reset so contents survive reset
  always_ff @(posedge clk_i) begin
    if (v_i && w_i) begin
      for (int b = 0; b < int'(mask_width_lp); b++) begin
        if (write_mask_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= data_i[8*b +: 8];
        end
      end
    end
    if (v_i && !w_i) begin
      data_q <= mem_q[addr_i];
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/bp_me_wb_slave_mem.sv
// Wishbone classic slave wrapping a byte-maskable synchronous RAM.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   adr_i            : word address (byte offset already stripped)
//   dat_i, sel_i     : write data and byte-lane enables
//   cyc_i, stb_i     : request present when both are high
//   we_i             : 1 = write, 0 = read
//   dat_o            : read data, zero outside a read acknowledge
//   ack_o, err_o     : one-cycle acknowledge; err_o flags an out-of-range address
// A request waits wait_cycles_p cycles, is issued to the RAM, then acked.
module bp_me_wb_slave_mem
  import bp_me_wb_pkg::*;
#(
  parameter int unsigned data_width_p  = 64,
  parameter int unsigned els_p         = 256,
  parameter int unsigned adr_width_p   = 10,
  parameter int unsigned wait_cycles_p = 1
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [adr_width_p-1:0]    adr_i,
  input  logic [data_width_p-1:0]   dat_i,
  input  logic                      cyc_i,
  input  logic                      stb_i,
  input  logic [data_width_p/8-1:0] sel_i,
  input  logic                      we_i,
  output logic [data_width_p-1:0]   dat_o,
  output logic                      ack_o,
  output logic                      err_o
);

  localparam int unsigned idx_width_lp = wb_safe_clog2(els_p);
  localparam int unsigned cnt_width_lp = wb_wait_cnt_width_gp;
  localparam logic [cnt_width_lp-1:0] wait_load_lp =
    (wait_cycles_p > 0) ? cnt_width_lp'(wait_cycles_p - 1) : '0;
  localparam logic [adr_width_p:0] els_cmp_lp = (adr_width_p + 1)'(els_p);

  // Parameter legality checks
  if (!(data_width_p == 8 || data_width_p == 16 ||
        data_width_p == 32 || data_width_p == 64)) begin : g_bad_data_width
    $error("bp_me_wb_slave_mem: data_width_p must be 8, 16, 32 or 64");
  end
  if (wait_cycles_p > wb_wait_cycles_max_gp) begin : g_bad_wait_cycles
    $error("bp_me_wb_slave_mem: wait_cycles_p must be 0..15");
  end
  if (64'(els_p) > (64'd1 << adr_width_p)) begin : g_bad_els
    $error("bp_me_wb_slave_mem: els_p exceeds the address space");
  end

  bp_me_wb_state_e            state_q, state_d;
  logic [cnt_width_lp-1:0]    cnt_q, cnt_d;
  logic                       ack_q, ack_d;
  logic                       err_q, err_d;
  logic                       rd_vld_q, rd_vld_d;

  logic                       req_c;
  logic                       in_range_c;
  logic                       issue_c;
  logic                       mem_v_c;
  logic [data_width_p-1:0]    mem_rdata;

  assign req_c      = cyc_i & stb_i;
  assign in_range_c = ({1'b0, adr_i} < els_cmp_lp);

  // State and output registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= e_wb_idle;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  // Next-state logic; issue_c marks the single cycle that touches the RAM
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    issue_c  = 1'b0;
    unique case (state_q)
      e_wb_idle: begin
        if (req_c) begin
          if (wait_cycles_p == 0) begin
            issue_c = 1'b1;
            state_d = e_wb_ack;
          end else begin
            cnt_d   = wait_load_lp;
            state_d = e_wb_wait;
          end
        end
      end
      e_wb_wait: begin
        // Master withdrawing the strobe cancels the request outright
        if (!req_c) begin
          cnt_d   = '0;
          state_d = e_wb_idle;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - cnt_width_lp'(1);
        end else begin
          issue_c = 1'b1;
          state_d = e_wb_ack;
        end
      end
      // Always return to idle so the held strobe is not taken twice
      e_wb_ack: state_d = e_wb_idle;
      default:  state_d = e_wb_idle;
    endcase
    ack_d    = issue_c;
    err_d    = issue_c & ~in_range_c;
    rd_vld_d = issue_c & in_range_c & ~we_i;
    // Gate with reset so a write racing reset assertion never lands
    mem_v_c  = issue_c & in_range_c & reset_n_i;
  end

  bsg_mem_1rw_sync_mask_write_byte #(
    .els_p        (els_p),
    .data_width_p (data_width_p)
  ) u_mem (
    .clk_i        (clk_i),
    .v_i          (mem_v_c),
    .w_i          (we_i),
    .addr_i       (adr_i[idx_width_lp-1:0]),
    .data_i       (dat_i),
    .write_mask_i (sel_i),
    .data_o       (mem_rdata)
  );

  assign ack_o = ack_q;
  assign err_o = err_q;
  // RAM output register holds stale data; expose it only on a read ack
  assign dat_o = rd_vld_q ? mem_rdata : '0;

endmodule

// File: tb/tb_bp_me_wb_slave_mem.sv
// Self-checking bench: three slaves (wait states 1, 0, 3) sharing clock and
// reset, checked against an array model of memory and the latency rules.
module tb_bp_me_wb_slave_mem;

  logic        clk;
  logic        rst_n;
  logic [9:0]  adr   [3];
  logic [63:0] dat_w [3];
  logic [63:0] dat_r [3];
  logic        cyc   [3];
  logic        stb   [3];
  logic [7:0]  sel   [3];
  logic        we    [3];
  logic        ack   [3];
  logic        err   [3];

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  logic [63:0] mdl [3][256];

  bp_me_wb_slave_mem #(.data_width_p(64), .els_p(256), .adr_width_p(10), .wait_cycles_p(1)) u_dut0 (
    .clk_i(clk), .reset_n_i(rst_n), .adr_i(adr[0]), .dat_i(dat_w[0]), .cyc_i(cyc[0]), .stb_i(stb[0]),
    .sel_i(sel[0]), .we_i(we[0]), .dat_o(dat_r[0]), .ack_o(ack[0]), .err_o(err[0]));
  bp_me_wb_slave_mem #(.data_width_p(64), .els_p(256), .adr_width_p(10), .wait_cycles_p(0)) u_dut1 (
    .clk_i(clk), .reset_n_i(rst_n), .adr_i(adr[1]), .dat_i(dat_w[1]), .cyc_i(cyc[1]), .stb_i(stb[1]),
    .sel_i(sel[1]), .we_i(we[1]), .dat_o(dat_r[1]), .ack_o(ack[1]), .err_o(err[1]));
  bp_me_wb_slave_mem #(.data_width_p(64), .els_p(256), .adr_width_p(10), .wait_cycles_p(3)) u_dut2 (
    .clk_i(clk), .reset_n_i(rst_n), .adr_i(adr[2]), .dat_i(dat_w[2]), .cyc_i(cyc[2]), .stb_i(stb[2]),
    .sel_i(sel[2]), .we_i(we[2]), .dat_o(dat_r[2]), .ack_o(ack[2]), .err_o(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned wt(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw, input logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete transaction; starts and ends just after a falling edge
  task automatic txn(input int d, input bit w, input logic [9:0] a, input logic [63:0] wd,
                     input logic [7:0] s, output logic [63:0] obs);
    int unsigned lat;
    int unsigned i;
    bit inr;
    logic [63:0] e_dat;
    lat = 0;
    i = 0;
    obs = '0;
    inr = (a < 10'd256);
    e_dat = (!w && inr) ? mdl[d][a[7:0]] : 64'd0;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; dat_w[d] = wd; sel[d] = s;
    while (lat == 0 && i < wt(d) + 4) begin
      @(posedge clk); @(negedge clk);
      i++;
      if (ack[d]) lat = i;
    end
    chk($sformatf("latency d%0d adr %h", d, a), 64'(lat), 64'(wt(d) + 1));
    if (lat != 0) begin
      obs = dat_r[d];
      chk($sformatf("err d%0d adr %h", d, a), 64'(err[d]), 64'(!inr));
      if (!w) chk($sformatf("rdata d%0d adr %h", d, a), obs, e_dat);
    end
    if (w && inr) mdl[d][a[7:0]] = merge(mdl[d][a[7:0]], wd, s);
    cyc[d] = 1'b0; stb[d] = 1'b0;
    @(posedge clk); @(negedge clk);
    chk($sformatf("ack_single d%0d", d), 64'(ack[d]), 64'd0);
    chk($sformatf("dat_idle d%0d", d), dat_r[d], 64'd0);
  endtask

  // Request withdrawn after k sampled edges (k <= wait states): never acked
  task automatic abrt(input int d, input bit w, input logic [9:0] a, input logic [63:0] wd,
                      input logic [7:0] s, input int unsigned k);
    bit any;
    any = 1'b0;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; dat_w[d] = wd; sel[d] = s;
    repeat (k) @(posedge clk);
    #1;
    stb[d] = 1'b0;
    if ($urandom_range(0, 1) == 1) cyc[d] = 1'b0;
    for (int i = 0; i < int'(wt(d)) + 3; i++) begin
      @(negedge clk);
      any |= ack[d];
    end
    cyc[d] = 1'b0;
    chk($sformatf("abort_noack d%0d k%0d", d, k), 64'(any), 64'd0);
  endtask

  // Strobe held high for n reads: ack every wait+2 cycles, never back to back
  task automatic b2b(input int d, input int unsigned n);
    int unsigned per;
    logic [9:0] a;
    bit e_ack;
    per = wt(d) + 2;
    a = 10'($urandom_range(0, 255));
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b0; adr[d] = a; sel[d] = 8'($urandom);
    for (int unsigned c = 1; c <= n * per; c++) begin
      @(posedge clk); @(negedge clk);
      e_ack = ((c % per) == (per - 1));
      chk($sformatf("b2b_ack d%0d c%0d", d, c), 64'(ack[d]), 64'(e_ack));
      if (e_ack) begin
        chk($sformatf("b2b_dat d%0d c%0d", d, c), dat_r[d], mdl[d][a[7:0]]);
        a = 10'($urandom_range(0, 255));
        adr[d] = a;
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
  endtask

  // Reset asserted while the acknowledge is showing
  task automatic rst_mid_ack(input int d, input logic [9:0] a);
    int unsigned i;
    bit seen;
    i = 0;
    seen = 1'b0;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b0; adr[d] = a; sel[d] = 8'hFF;
    while (!seen && i < wt(d) + 4) begin
      @(posedge clk); @(negedge clk);
      i++;
      if (ack[d]) seen = 1'b1;
    end
    chk($sformatf("midack_reached d%0d", d), 64'(seen), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midack_ack", 64'(ack[d]), 64'd0);
    chk("midack_err", 64'(err[d]), 64'd0);
    chk("midack_dat", dat_r[d], 64'd0);
    cyc[d] = 1'b0; stb[d] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] obs;
    logic [9:0]  a;
    logic [7:0]  s;
    bit          w;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      adr[d] = '0; dat_w[d] = '0; cyc[d] = 1'b0; stb[d] = 1'b0; sel[d] = '0; we[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_ack d%0d", d), 64'(ack[d]), 64'd0);
      chk($sformatf("rst_err d%0d", d), 64'(err[d]), 64'd0);
      chk($sformatf("rst_dat d%0d", d), dat_r[d], 64'd0);
    end
    rst_n = 1'b1;

    // Known contents everywhere
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 256; i++)
        txn(d, 1'b1, 10'(i), {$urandom(), $urandom()}, 8'hFF, obs);

    // Full write then read
    txn(0, 1'b1, 10'h010, 64'hDEADBEEF_CAFEF00D, 8'hFF, obs);
    txn(0, 1'b0, 10'h010, 64'd0, 8'h00, obs);
    chk("full_wr_rd", obs, 64'hDEADBEEF_CAFEF00D);

    // Partial write
    txn(0, 1'b1, 10'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, obs);
    txn(0, 1'b1, 10'd5, 64'h0000_0000_0000_1234, 8'h03, obs);
    txn(0, 1'b0, 10'd5, 64'd0, 8'h00, obs);
    chk("partial_wr", obs, 64'hFFFF_FFFF_FFFF_1234);

    // Empty byte mask changes nothing
    txn(0, 1'b1, 10'd5, 64'h1111_2222_3333_4444, 8'h00, obs);
    txn(0, 1'b0, 10'd5, 64'd0, 8'h00, obs);
    chk("sel_zero", obs, 64'hFFFF_FFFF_FFFF_1234);

    // Back-to-back reads with the strobe held
    b2b(1, 4);
    b2b(0, 3);
    b2b(2, 3);

    // Aborted write in the second wait cycle, then read back the old value
    abrt(2, 1'b1, 10'd7, 64'h0123_4567_89AB_CDEF, 8'hFF, 2);
    txn(2, 1'b0, 10'd7, 64'd0, 8'h00, obs);

    // Out-of-range write and read, address zero untouched
    txn(0, 1'b1, 10'h100, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, obs);
    txn(0, 1'b0, 10'h100, 64'd0, 8'h00, obs);
    chk("oor_rdata", obs, 64'd0);
    txn(0, 1'b0, 10'h000, 64'd0, 8'h00, obs);

    // Strobe without cycle, and cycle without strobe, are ignored
    begin
      bit any;
      any = 1'b0;
      stb[1] = 1'b1; cyc[1] = 1'b0; we[1] = 1'b1; adr[1] = 10'd3; dat_w[1] = '1; sel[1] = 8'hFF;
      repeat (4) begin @(negedge clk); any |= ack[1]; end
      stb[1] = 1'b0; cyc[1] = 1'b1;
      repeat (4) begin @(negedge clk); any |= ack[1]; end
      cyc[1] = 1'b0;
      chk("no_req_noack", 64'(any), 64'd0);
      txn(1, 1'b0, 10'd3, 64'd0, 8'h00, obs);
    end

    // Reset during wait: write is dropped, next request has normal latency
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 10'd9; dat_w[2] = 64'hFEED_FACE_0BAD_F00D; sel[2] = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midwait_ack", 64'(ack[2]), 64'd0);
    chk("midwait_err", 64'(err[2]), 64'd0);
    chk("midwait_dat", dat_r[2], 64'd0);
    cyc[2] = 1'b0; stb[2] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    txn(2, 1'b0, 10'd9, 64'd0, 8'h00, obs);

    // Reset during the acknowledge, in-range read and out-of-range read
    rst_mid_ack(0, 10'd20);
    txn(0, 1'b0, 10'd20, 64'd0, 8'h00, obs);
    rst_mid_ack(2, 10'h120);
    txn(2, 1'b0, 10'd21, 64'd0, 8'h00, obs);

    // Randomized mix of reads, writes, masks, out-of-range and aborts
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 120; i++) begin
        a = 10'($urandom_range(0, 299));
        w = 1'($urandom_range(0, 1));
        s = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        if (wt(d) > 0 && $urandom_range(0, 5) == 0)
          abrt(d, w, a, {$urandom(), $urandom()}, s, $urandom_range(1, wt(d)));
        else
          txn(d, w, a, {$urandom(), $urandom()}, s, obs);
      end
    end

    // Final read-back sweep of a slice of each memory
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 16; i++)
        txn(d, 1'b0, 10'($urandom_range(0, 255)), 64'd0, 8'h00, obs);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bp_me_wb_slave_mem.md
BP_ME_WB_SLAVE_MEM -- requirements
Module: bp_me_wb_slave_mem

Interface
REQ-001 The block SHALL have parameter data_width_p, default 64, meaning bus data width in bits; legal values are 8, 16, 32 and 64.
REQ-002 The block SHALL have parameter els_p, default 256, meaning memory depth in bus words.
REQ-003 The block SHALL have parameter adr_width_p, default 10, meaning Wishbone word-address width; adr_width_p >= clog2(els_p).
REQ-004 The block SHALL have parameter wait_cycles_p, default 1, meaning wait states inserted before ack; legal range is 0..15.
REQ-005 clk_i  input  1  sole clock; all state SHALL update on the rising edge.
REQ-006 reset_n_i  input  1  reset, asynchronous and active-low.
REQ-007 adr_i  input  adr_width_p  word address, with byte offset already stripped by the master.
REQ-008 dat_i  input  data_width_p  write data.
REQ-009 cyc_i  input  1  bus cycle active.
REQ-010 stb_i  input  1  strobe; a request SHALL be present only when cyc_i & stb_i.
REQ-011 sel_i  input  data_width_p/8  byte-lane write enables.
REQ-012 we_i  input  1  1 = write, 0 = read.
REQ-013 dat_o  output  data_width_p  read data.
REQ-014 ack_o  output  1  single-cycle transfer acknowledge.
REQ-015 err_o  output  1  out-of-range flag; it SHALL pulse together with ack_o.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and ACK.
REQ-017 The issue cycle SHALL be the cycle in which the FSM moves to ACK.
REQ-018 IDLE: if cyc_i & stb_i and wait_cycles_p == 0, the FSM SHALL issue and go to ACK; if cyc_i & stb_i otherwise, it SHALL load the counter with wait_cycles_p-1 and go to WAIT; else it SHALL stay in IDLE.
REQ-019 WAIT: while the counter is nonzero, the FSM SHALL decrement it.
REQ-020 WAIT: when the counter is zero, the FSM SHALL issue and go to ACK.
REQ-021 If cyc_i & stb_i is low in any WAIT cycle, including the would-be issue cycle, the FSM SHALL abort to IDLE with no memory access and no ack.
REQ-022 ACK: ack_o SHALL be high for exactly this cycle, and the FSM SHALL return to IDLE unconditionally; the still-high stb_i of the acknowledged request SHALL NOT be re-accepted.
REQ-023 Latency: for a request first seen in cycle N, ack_o SHALL rise in cycle N+wait_cycles_p+1.
REQ-024 Throughput: back-to-back requests SHALL complete one every wait_cycles_p+2 cycles.
REQ-025 Write (we_i=1): in the issue cycle, memory word adr_i SHALL be updated only in the byte lanes where sel_i is set; other lanes keep their value.
REQ-026 A write with sel_i == 0 SHALL be acked and SHALL change nothing.
REQ-027 Read (we_i=0): the memory SHALL be read in the issue cycle, and dat_o SHALL present the word during the ACK cycle.
REQ-028 dat_o SHALL be 0 whenever ack_o is 0.
REQ-029 Out-of-range (adr_i >= els_p): the request SHALL be acked with err_o=1 in the same cycle.
REQ-030 An out-of-range write SHALL be discarded.
REQ-031 An out-of-range read SHALL return dat_o=0.
REQ-032 Only the low clog2(els_p) bits of adr_i SHALL index the memory, and only after the range check passes.
REQ-033 stb_i without cyc_i SHALL be ignored.
REQ-034 Inputs other than cyc_i/stb_i SHALL be sampled only in the issue cycle.

Reset
REQ-035 Asserting reset_n_i low SHALL immediately force IDLE, counter=0, ack_o=0, err_o=0 and dat_o=0, including mid-WAIT or mid-ACK.
REQ-036 Reset SHALL NOT clear memory contents.
REQ-037 A write whose issue edge coincides with reset assertion SHALL be discarded.
REQ-038 The first request SHALL be accepted in the first rising edge after reset_n_i deasserts.

Structure
REQ-039 The state enum SHALL be defined in shared package bp_me_wb_pkg, so other WB blocks reuse it.
REQ-040 The wait-counter width constant SHALL be defined in bp_me_wb_pkg.
REQ-041 Storage SHALL be one instance of bsg_mem_1rw_sync_mask_write_byte, els_p x data_width_p, with its v_i/w_i driven in the issue cycle only.
REQ-042 The FSM, counter and range check SHALL reside in this module.
REQ-043 Elaboration SHALL fail if data_width_p is not 8/16/32/64, if wait_cycles_p > 15, or if els_p > 2^adr_width_p.

Verification
REQ-044 Full write then read, wait_cycles_p=1: write adr 0x010, dat 0xDEADBEEF_CAFEF00D, sel 0xFF, then read adr 0x010 -> ack_o at N+2 both times; read dat_o=0xDEADBEEF_CAFEF00D, err_o=0.
REQ-045 Partial write: write 0xFFFF_FFFF_FFFF_FFFF to adr 5 with sel 0xFF, then 0x0000_0000_0000_1234 with sel 0x03, then read adr 5 -> 0xFFFF_FFFF_FFFF_1234.
REQ-046 Back-to-back, wait_cycles_p=0, stb held high for 4 reads -> ack_o on cycles N+1, N+3, N+5, N+7; never on consecutive cycles.
REQ-047 Abort: wait_cycles_p=3, write to adr 7 with stb dropped in the 2nd WAIT cycle, then read adr 7 -> no ack for the aborted write; old value returned.
REQ-048 Out-of-range: els_p=256, write then read adr 0x100 -> ack_o=1 and err_o=1 for both; dat_o=0; adr 0x000 unchanged.
REQ-049 Reset mid-WAIT: assert reset_n_i low during WAIT -> ack_o/err_o/dat_o=0 asynchronously; the next request after release completes with normal latency.
